// File: rtl/axis_frame_monitor.sv
// AXI4-Stream video frame monitor.
// Follows the frame raster of an incoming video stream (SOF on tuser, EOL on
// tlast), checks framing and byte enables, and reports clean frames with a
// checksum. Optionally throttles the source with LFSR-driven backpressure.
module axis_frame_monitor #(
  parameter int          DATA_WIDTH = 32,
  parameter int          X_SIZE     = 640,
  parameter int          Y_SIZE     = 480,
  parameter int          READY_MODE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tuser,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic [DATA_WIDTH-1:0]   checksum,
  output logic [15:0]             err_count,
  output logic                    err_sof,
  output logic                    err_eol,
  output logic                    err_keep,
  output logic                    in_sync
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int XW     = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW     = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [XW-1:0]           x_q;
  logic [YW-1:0]           y_q;
  logic [DATA_WIDTH-1:0]   sum_q;
  logic                    frame_bad_q;
  logic                    frame_done_q;
  logic [15:0]             frame_count_q;
  logic [DATA_WIDTH-1:0]   checksum_q;
  logic [15:0]             err_count_q;
  logic                    err_sof_q;
  logic                    err_eol_q;
  logic                    err_keep_q;
  logic [15:0]             lfsr_q;
  logic                    rdy_en_q;

  logic                    beat;
  logic                    in_run;
  logic                    accept;
  logic [XW-1:0]           px;
  logic [YW-1:0]           py;
  logic                    at_eol;
  logic                    at_end;
  logic                    sof_err;
  logic                    eol_err;
  logic                    keep_err;
  logic                    any_err;
  logic                    bad_d;
  logic [DATA_WIDTH-1:0]   sum_d;
  logic                    lfsr_fb;

  // Ready is held low until the first cycle out of reset; in mode 1 it is
  // additionally gated by two LFSR bits (high roughly 3 cycles in 4).
  assign s_tready = rdy_en_q & ((READY_MODE == 0) | lfsr_q[0] | lfsr_q[1]);

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  assign beat   = s_tvalid & s_tready;
  assign in_run = (state_q == ST_RUN);
  // In SYNC only a start-of-frame beat is looked at; everything else is dropped.
  assign accept = beat & (in_run | s_tuser);

  // A tuser beat is always pixel (0,0), whether it opens or restarts a frame.
  assign px    = s_tuser ? '0 : x_q;
  assign py    = s_tuser ? '0 : y_q;
  assign sum_d = s_tuser ? s_tdata : sum_q + s_tdata;

  assign at_eol   = (px == X_LAST);
  assign at_end   = at_eol & (py == Y_LAST);
  assign sof_err  = s_tuser & in_run;
  assign eol_err  = (s_tlast != at_eol);
  assign keep_err = (s_tkeep != {KEEP_W{1'b1}});
  assign any_err  = sof_err | eol_err | keep_err;
  // The SOF error belongs to the abandoned frame, so it does not taint the restart.
  assign bad_d    = (s_tuser ? 1'b0 : frame_bad_q) | keep_err | eol_err;

  // Frame-tracking FSM with its registered statistics and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      x_q           <= '0;
      y_q           <= '0;
      sum_q         <= '0;
      frame_bad_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      checksum_q    <= '0;
      err_count_q   <= '0;
      err_sof_q     <= 1'b0;
      err_eol_q     <= 1'b0;
      err_keep_q    <= 1'b0;
      lfsr_q        <= LFSR_SEED;
      rdy_en_q      <= 1'b0;
    end else begin
      rdy_en_q     <= 1'b1;
      lfsr_q       <= {lfsr_fb, lfsr_q[15:1]};
      frame_done_q <= 1'b0;
      if (accept) begin
        sum_q       <= sum_d;
        frame_bad_q <= bad_d;
        if (any_err) begin
          if (err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
          end
          err_sof_q  <= err_sof_q  | sof_err;
          err_eol_q  <= err_eol_q  | eol_err;
          err_keep_q <= err_keep_q | keep_err;
        end
        if (eol_err) begin
          // Line structure is lost: wait for the next start of frame.
          state_q <= ST_SYNC;
          x_q     <= '0;
          y_q     <= '0;
        end else if (at_end) begin
          state_q <= ST_SYNC;
          x_q     <= '0;
          y_q     <= '0;
          if (!bad_d) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
            checksum_q    <= sum_d;
          end
        end else begin
          state_q <= ST_RUN;
          if (at_eol) begin
            x_q <= '0;
            y_q <= py + YW'(1);
          end else begin
            x_q <= px + XW'(1);
            y_q <= py;
          end
        end
      end
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign checksum    = checksum_q;
  assign err_count   = err_count_q;
  assign err_sof     = err_sof_q;
  assign err_eol     = err_eol_q;
  assign err_keep    = err_keep_q;
  assign in_sync     = in_run;

endmodule
